// File: rtl/neur_mac_unit.sv
// Eight-lane signed 17x17 multiply-accumulate unit with a two-stage pipeline
// (lane products, then beat sum + accumulate) sequenced by an issue/drain FSM.
module neur_mac_unit #(
    parameter int ACC_W = 32,
    parameter int LANES = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [2:0]            mode_i,
    input  logic [ACC_W-1:0]      acc_init_i,
    input  logic [LANES*17-1:0]   weight_vals_i,
    input  logic [LANES*17-1:0]   activations_i,
    output logic [1:0]            iteration_o,
    output logic                  ready_o,
    output logic [ACC_W-1:0]      result_o,
    output logic                  result_valid_o
);

    localparam int DATA_W   = 17;
    localparam int COEF_W   = 17;
    localparam int STAGES   = 2;
    localparam int PROD_W   = DATA_W + COEF_W;
    localparam int SUM_W    = (ACC_W > 40) ? ACC_W : 40;
    localparam int SCALE_SH = 12;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                    state;
    logic [1:0]                mode_q;
    logic [1:0]                beat_cnt;
    logic signed [ACC_W-1:0]   acc_q;
    logic                      vld_p0;
    logic                      vld_p1;
    logic signed [PROD_W-1:0]  w_p0    [LANES];
    logic signed [PROD_W-1:0]  a_p0    [LANES];
    logic signed [PROD_W-1:0]  prod_p1 [LANES];
    logic signed [SUM_W-1:0]   sum_p1;
    logic signed [ACC_W-1:0]   contrib_p1;
    logic signed [ACC_W-1:0]   acc_next;
    logic                      unused_mode;

    assign unused_mode = mode_i[2];

    function automatic logic [1:0] last_beat(input logic [1:0] mode);
        case (mode)
            2'b00:   return 2'd3;
            2'b10:   return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // Mode 11 scales each product down by 2^12 (arithmetic) before summing.
    function automatic logic signed [SUM_W-1:0] scale_product(
        input logic signed [PROD_W-1:0] p,
        input logic                     shift_en
    );
        logic signed [SUM_W-1:0] ext;
        ext = SUM_W'(p);
        return shift_en ? (ext >>> SCALE_SH) : ext;
    endfunction

    // Truncation to ACC_W gives the modulo-2^ACC_W wrap; no saturation.
    function automatic logic signed [ACC_W-1:0] wrap_acc(input logic signed [SUM_W-1:0] s);
        return ACC_W'(s);
    endfunction

    // Stage 0: unpack lanes, sign-extended to product width
    always_comb begin
        vld_p0 = (state == ISSUE);
        for (int k = 0; k < LANES; k++) begin
            w_p0[k] = PROD_W'($signed(weight_vals_i[(LANES-1-k)*DATA_W +: DATA_W]));
            a_p0[k] = PROD_W'($signed(activations_i[(LANES-1-k)*COEF_W +: COEF_W]));
        end
    end

    // Stage 1: registered lane products
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
            for (int k = 0; k < LANES; k++) prod_p1[k] <= '0;
        end else begin
            vld_p1 <= vld_p0;
            for (int k = 0; k < LANES; k++) prod_p1[k] <= w_p0[k] * a_p0[k];
        end
    end

    // Stage 2: beat contribution and next accumulator value
    always_comb begin
        sum_p1 = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_p1 = sum_p1 + scale_product(prod_p1[k], mode_q == 2'b11);
        end
        contrib_p1 = wrap_acc(sum_p1);
        acc_next   = acc_q + contrib_p1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            mode_q         <= 2'b00;
            beat_cnt       <= 2'd0;
            acc_q          <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            iteration_o    <= 2'd0;
            ready_o        <= 1'b1;
        end else begin
            result_valid_o <= 1'b0;
            if (vld_p1) acc_q <= acc_next;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mode_q      <= mode_i[1:0];
                        acc_q       <= acc_init_i;
                        beat_cnt    <= 2'd0;
                        iteration_o <= 2'd0;
                        ready_o     <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (beat_cnt == last_beat(mode_q)) begin
                        beat_cnt    <= 2'd0;
                        iteration_o <= 2'd0;
                        state       <= DRAIN;
                    end else begin
                        beat_cnt    <= beat_cnt + 2'd1;
                        iteration_o <= beat_cnt + 2'd1;
                    end
                end
                DRAIN: begin
                    // Last stage-2 add lands this cycle; forward it so the
                    // result is visible throughout DONE.
                    result_o       <= acc_next;
                    result_valid_o <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/neur_mac_unit.md
NEUR_MAC_UNIT -- requirements
Module: neur_mac_unit

Interface
REQ-001 SHALL have parameter ACC_W, default 32, accumulator and result width in bits.
REQ-002 SHALL have parameter LANES, default 8, number of 17-bit multiply lanes; only 8 is supported.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start_i, input, 1: request a new MAC operation; accepted only when ready_o=1.
REQ-006 SHALL have port mode_i, input, 3: neural mode; bits [1:0] select the beat count and product scaling; bit 2 is unused.
REQ-007 SHALL have port acc_init_i, input, ACC_W: accumulator start value (bias or previous partial sum), sampled at start.
REQ-008 SHALL have port weight_vals_i, input, 136: eight signed 17-bit weights; lane k at bits [(7-k)*17 +: 17].
REQ-009 SHALL have port activations_i, input, 136: eight signed 17-bit activations, same lane packing.
REQ-010 SHALL have port iteration_o, output, 2: current beat index, driven to the upstream decoder.
REQ-011 SHALL have port ready_o, output, 1: idle and able to accept start_i.
REQ-012 SHALL have port result_o, output, ACC_W: final accumulated sum.
REQ-013 SHALL have port result_valid_o, output, 1: one-cycle pulse when result_o is updated.

Function
REQ-014 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-015 SHALL, in IDLE with start_i=1, latch mode_i[1:0] and acc_init_i, clear the beat counter, and enter ISSUE.
REQ-016 SHALL use beat count N = 4 for mode 00, 1 for mode 01, 2 for mode 10, and 1 for mode 11.
REQ-017 SHALL, in ISSUE, drive iteration_o = beat counter and advance the counter once per cycle; after beat N-1 the state goes to DRAIN.
REQ-018 SHALL drive iteration_o = 0 in every state other than ISSUE.
REQ-019 SHALL, in pipeline stage 1, register each cycle the eight signed 34-bit lane products w_k*a_k of the current beat's inputs.
REQ-020 SHALL require the bench/upstream to present the inputs for beat i during the cycle iteration_o = i.
REQ-021 SHALL, in pipeline stage 2, form the beat contribution and add it to the accumulator one cycle after stage 1.
REQ-022 SHALL form the beat contribution as the signed sum of the 8 products for modes 00/01/10, and as the signed sum of (product >>> 12, arithmetic) for mode 11.
REQ-023 SHALL truncate the contribution to ACC_W and make accumulation wrap modulo 2^ACC_W, with no saturation.
REQ-024 SHALL, in DRAIN, wait one cycle for the last stage-2 add, then enter DONE.
REQ-025 SHALL, in DONE, load result_o from the accumulator, pulse result_valid_o for exactly one cycle, and return to IDLE.
REQ-026 SHALL have latency of N+2 cycles from the start_i acceptance edge to the result_valid_o cycle.
REQ-027 SHALL hold result_o until the next DONE.
REQ-028 SHALL drive ready_o = 1 only in IDLE; start_i outside IDLE is ignored and not queued.
REQ-029 SHALL ignore any change of mode_i or acc_init_i after acceptance.
REQ-030 SHALL accept start_i in the IDLE cycle immediately after DONE, so back-to-back operations complete every N+3 cycles.

Reset
REQ-031 SHALL, while rst_ni=0 (asynchronously), force state IDLE, counter 0, accumulator 0, pipeline registers 0, result_o=0, result_valid_o=0, iteration_o=0, ready_o=1.
REQ-032 SHALL, on reset asserted mid-operation, discard the operation and produce no result_valid_o pulse.

Verification
REQ-033 SHALL cover: mode 01, acc_init 0, lanes 0/2/4/6 w=2 a=1, other lanes 0 -> result_valid 3 cycles after start, result 8.
REQ-034 SHALL cover: mode 00, acc_init 10, lanes 0/2/4/6 w=1 a=3 every beat -> iteration_o 0,1,2,3, then result 58 at cycle 6.
REQ-035 SHALL cover: mode 11, lane 0 w=4096 a=5, others 0 -> result 5; lane 0 w=-4096 a=5 -> result 0xFFFFFFFB.
REQ-036 SHALL cover: mode 01, acc_init 0x7FFFFFFF, single product 1 -> result 0x80000000 (wrap).
REQ-037 SHALL cover: rst_ni low during ISSUE of a mode 00 operation -> no result_valid, all outputs 0, ready_o=1; next operation correct.
REQ-038 SHALL cover: start_i held high through busy -> exactly one operation per IDLE acceptance; mode_i changed mid-operation has no effect.
